// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared register-file types and defaults
//
// Purpose: default sizes, the hardwired-zero register index and common
//          address/data types used by the register file and its scoreboard.
// Ports:   none (package).
package rv_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int REG_ZERO      = 0;

    typedef logic [4:0]              reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] xword_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write busy scoreboard
//
// Purpose: tracks which registers have an outstanding multi-cycle producer.
//          A same-cycle issue and writeback to one register leaves it busy,
//          because the issue is a newer producer claiming it.
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   set_i       in   producer issuing (mark set_rd_i busy)
//   set_rd_i    in   register to mark busy
//   clr_i       in   writeback (clear clr_rd_i)
//   clr_rd_i    in   register to clear
//   busy_o      out  registered busy vector, bit 0 always 0
//   any_busy_o  out  OR of all busy bits
module regfile_scoreboard
    import rv_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_i,
    input  logic [AW-1:0]    set_rd_i,
    input  logic             clr_i,
    input  logic [AW-1:0]    clr_rd_i,
    output logic [NREGS-1:0] busy_o,
    output logic             any_busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        // Clear first, then set, so a same-cycle claim wins.
        if (clr_i && (clr_rd_i != AW'(REG_ZERO))) begin
            busy_d[clr_rd_i] = 1'b0;
        end
        if (set_i && (set_rd_i != AW'(REG_ZERO))) begin
            busy_d[set_rd_i] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign any_busy_o = |busy_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with busy scoreboard
//
// Purpose: NREGS x XLEN register file, register 0 hardwired to zero, NRD
//          combinational read ports, one writeback port, and a busy
//          scoreboard for multi-cycle producers.
//          Optional macro REGFILE_BYPASS_EN: same-cycle writeback data and
//          busy-clear are forwarded to matching read ports.
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   rs_addr      in   NRD*AW packed read addresses, port i at [i*AW +: AW]
//   rs_data      out  NRD*XLEN packed read data, port i at [i*XLEN +: XLEN]
//   rs_busy      out  NRD per-port pending-write flags
//   we           in   writeback enable
//   rd           in   writeback destination
//   wdata        in   writeback data
//   issue_valid  in   multi-cycle producer issuing
//   issue_rd     in   destination to mark busy
//   any_busy     out  OR of all busy bits
module regfile_mp
    import rv_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEFAULT,
    parameter  int NREGS = NREGS_DEFAULT,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic              we,
    input  logic [AW-1:0]     rd,
    input  logic [XLEN-1:0]   wdata,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    output logic              any_busy
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_vec;
    logic             wr_en;

    assign wr_en = we && (rd != AW'(REG_ZERO));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wr_en) begin
            regs_q[rd] <= wdata;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_i      (issue_valid),
        .set_rd_i   (issue_rd),
        .clr_i      (we),
        .clr_rd_i   (rd),
        .busy_o     (busy_vec),
        .any_busy_o (any_busy)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy;

        assign addr = rs_addr[i*AW +: AW];

        always_comb begin
            data = '0;
            busy = 1'b0;
            if (addr != AW'(REG_ZERO)) begin
                data = regs_q[addr];
                busy = busy_vec[addr];
            end
`ifdef REGFILE_BYPASS_EN
            // A consumer reading the register being written this cycle
            // sees the new value and no hazard.
            if (wr_en && (rd == addr)) begin
                data = wdata;
                busy = 1'b0;
            end
`endif
        end

        assign rs_data[i*XLEN +: XLEN] = data;
        assign rs_busy[i]              = busy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [NRD*AW-1:0]   rs_addr = '0;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic                we = 1'b0;
    logic [AW-1:0]       rd = '0;
    logic [XLEN-1:0]     wdata = '0;
    logic                issue_valid = 1'b0;
    logic [AW-1:0]       issue_rd = '0;
    logic                any_busy;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Architectural model: register contents and pending flags.
    logic [XLEN-1:0] m_reg [NREGS];
    bit   [NREGS-1:0] m_busy;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk         (clk),
        .reset       (reset),
        .rs_addr     (rs_addr),
        .rs_data     (rs_data),
        .rs_busy     (rs_busy),
        .we          (we),
        .rd          (rd),
        .wdata       (wdata),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .any_busy    (any_busy)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREGS; r++) m_reg[r] = '0;
        m_busy = '0;
    endtask

    initial model_clear();

    always @(negedge reset) model_clear();

    // Model update on each edge from the rules: writeback stores data and
    // retires the pending flag; an issue marks pending and overrides a
    // same-cycle retire; register 0 never changes.
    always @(posedge clk) begin
        if (reset) begin
            if (we && rd != 0) begin
                m_reg[rd] = wdata;
                m_busy[rd] = 1'b0;
            end
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
    end

    // Mid-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NRD; i++) begin
                logic [AW-1:0]   a;
                logic [XLEN-1:0] ed;
                logic            eb;
                a  = rs_addr[i*AW +: AW];
                ed = (a == 0) ? '0 : m_reg[a];
                eb = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
                if (we && rd != 0 && rd == a) begin
                    ed = wdata;
                    eb = 1'b0;
                end
`endif
                chk($sformatf("model_rs_data%0d", i), rs_data[i*XLEN +: XLEN], ed);
                chk($sformatf("model_rs_busy%0d", i), {31'b0, rs_busy[i]}, {31'b0, eb});
            end
            chk("model_any_busy", {31'b0, any_busy}, {31'b0, (m_busy != 0)});
        end
    end

    task automatic drive(input logic w, input logic [4:0] r, input logic [31:0] d,
                         input logic iv, input logic [4:0] ir,
                         input logic [4:0] a0, input logic [4:0] a1);
        @(posedge clk);
        #1;
        we = w; rd = r; wdata = d;
        issue_valid = iv; issue_rd = ir;
        rs_addr = {a1, a0};
    endtask

    task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, a0, a1);
    endtask

    initial begin
        // Reset held: outputs must be zero.
        @(posedge clk);
        @(negedge clk);
        chk("rst_any_busy", {31'b0, any_busy}, 32'h0);
        chk("rst_rs_data0", rs_data[31:0], 32'h0);
        chk("rst_rs_busy", {30'b0, rs_busy}, 32'h0);
        chk_en = 1'b1;
        @(posedge clk);
        #1 reset = 1'b1;

        // Read every address on both ports.
        for (int a = 0; a < NREGS; a++) idle(5'(a), 5'(31 - a));

        // Plain write then read; write to register 0 ignored.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd5, 5'd5);
        @(negedge clk);
        chk("wr5_port0", rs_data[31:0], 32'hDEADBEEF);
        chk("wr5_port1", rs_data[63:32], 32'hDEADBEEF);
        drive(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        @(negedge clk);
        chk("wr0_ignored", rs_data[31:0], 32'h0);

        // Issue to 7, observe hazard, retire with writeback.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd7);
        idle(5'd0, 5'd7);
        @(negedge clk);
        chk("busy7_port1", {31'b0, rs_busy[1]}, 32'h1);
        chk("busy7_any", {31'b0, any_busy}, 32'h1);
        drive(1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 5'd0, 5'd7);
        idle(5'd0, 5'd7);
        @(negedge clk);
        chk("ret7_busy", {31'b0, rs_busy[1]}, 32'h0);
        chk("ret7_any", {31'b0, any_busy}, 32'h0);
        chk("ret7_data", rs_data[63:32], 32'h55);

        // Same-cycle issue and writeback to a busy register: stays busy.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0);
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd0, 5'd0);
        idle(5'd9, 5'd9);
        @(negedge clk);
        chk("setwins_busy", {30'b0, rs_busy}, 32'h3);
        chk("setwins_data", rs_data[31:0], 32'h99);
        drive(1'b1, 5'd9, 32'h9A, 1'b0, 5'd0, 5'd0, 5'd0);

        // Same-cycle write and read of register 3.
        drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd3, 5'd0);
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        chk("bypass_data", rs_data[31:0], 32'hA5A5A5A5);
`else
        chk("nobypass_data", rs_data[31:0], 32'h0);
`endif

        // Issue to 0 never marks busy.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        @(negedge clk);
        chk("issue0_any", {31'b0, any_busy}, 32'h0);

        // Reset mid-cycle discards busy state and register contents.
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd2, 5'd0, 5'd0);
        idle(5'd2, 5'd5);
        #1;
        chk("pre_rst_busy2", {31'b0, rs_busy[0]}, 32'h1);
        reset = 1'b0;
        #3;
        chk("mid_rst_any", {31'b0, any_busy}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_data2", rs_data[31:0], 32'h0);
        chk("post_rst_busy2", {31'b0, rs_busy[0]}, 32'h0);
        chk("post_rst_data5", rs_data[63:32], 32'h0);

        // Late writeback after reset is written normally.
        drive(1'b1, 5'd2, 32'h77, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd2, 5'd0);
        @(negedge clk);
        chk("late_wb_data", rs_data[31:0], 32'h77);
        chk("late_wb_busy", {31'b0, rs_busy[0]}, 32'h0);

        // Mixed traffic, checked against the model each cycle.
        for (int k = 0; k < 24; k++) begin
            drive((k % 3) != 0, 5'((k + 10) & 31), 32'(k) * 32'h01010101,
                  (k % 2) == 1, 5'((k * 7) & 31), 5'(k & 31), 5'((k + 10) & 31));
        end
        for (int k = 0; k < 32; k++) drive(1'b1, 5'(k), 32'hC0DE0000 | 32'(k), 1'b0, 5'd0, 5'(k), 5'(31 - k));
        idle(5'd1, 5'd31);
        @(negedge clk);
        chk("drain_any", {31'b0, any_busy}, 32'h0);
        chk("drain_data1", rs_data[31:0], 32'hC0DE0001);

        @(posedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
